// File: rtl/apb_arb2_if.sv
// APB bus bundle between the two-requester arbiter (master) and the timer register slave.
interface apb_arb2_if #(
    parameter int AW = 12
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_arb2.sv
// Round-robin arbiter and APB master sharing one slave port between a CPU and a debug requester.
// All APB and completion outputs are registered from the decoded next state.
module apb_arb2 #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req,
    input  logic          r0_write,
    input  logic [AW-1:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    input  logic [3:0]    r0_strb,
    output logic          r0_done,
    output logic [31:0]   r0_rdata,
    output logic          r0_err,
    input  logic          r1_req,
    input  logic          r1_write,
    input  logic [AW-1:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    input  logic [3:0]    r1_strb,
    output logic          r1_done,
    output logic [31:0]   r1_rdata,
    output logic          r1_err,
    output logic          busy,
    output logic          owner,
    apb_arb2_if.master    apb
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};
    localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s, cnt_inc_s;
    logic            last_owner_r, owner_r, win_s, timeout_s;
    logic            psel_r, penable_r, pwrite_r, busy_r;
    logic [AW-1:0]   paddr_r;
    logic [31:0]     pwdata_r;
    logic [3:0]      pstrb_r;
    logic            r0_done_r, r1_done_r, r0_err_r, r1_err_r;
    logic [31:0]     r0_rdata_r, r1_rdata_r;
    logic [31:0]     cap_rdata_s;
    logic            cap_err_s;

    assign cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_ONE);
    assign timeout_s = (TIMEOUT > 0) && (cnt_inc_s == TMO_VAL) && !apb.pready;
    // A timed-out access reports zero data with an error regardless of pslverr.
    assign cap_rdata_s = (apb.pready && !pwrite_r) ? apb.prdata : 32'h0000_0000;
    assign cap_err_s   = apb.pready ? apb.pslverr : 1'b1;

    // Winner selection and next-state / wait-counter decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (r0_req && r1_req) begin
            win_s = ~last_owner_r;
        end else if (r0_req) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
        case (state_r)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    state_nxt_s = ST_SETUP;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_nxt_s = cnt_inc_s;
                if (apb.pready || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, wait counter and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            last_owner_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (state_r == ST_RESP) begin
                last_owner_r <= owner_r;
            end
        end
    end

    // APB drive registers; request fields are latched only when a grant is made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            busy_r    <= 1'b0;
            owner_r   <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= 32'h0000_0000;
            pstrb_r   <= 4'h0;
        end else begin
            psel_r    <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
            penable_r <= (state_nxt_s == ST_ACCESS);
            busy_r    <= (state_nxt_s != ST_IDLE);
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_SETUP)) begin
                owner_r  <= win_s;
                pwrite_r <= win_s ? r1_write : r0_write;
                paddr_r  <= win_s ? r1_addr : r0_addr;
                pwdata_r <= win_s ? r1_wdata : r0_wdata;
                if (win_s) begin
                    pstrb_r <= r1_write ? r1_strb : 4'h0;
                end else begin
                    pstrb_r <= r0_write ? r0_strb : 4'h0;
                end
            end
        end
    end

    // Completion pulse and per-requester response capture at the end of ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_done_r  <= 1'b0;
            r1_done_r  <= 1'b0;
            r0_rdata_r <= 32'h0000_0000;
            r1_rdata_r <= 32'h0000_0000;
            r0_err_r   <= 1'b0;
            r1_err_r   <= 1'b0;
        end else begin
            r0_done_r <= (state_r == ST_ACCESS) && (state_nxt_s == ST_RESP) && !owner_r;
            r1_done_r <= (state_r == ST_ACCESS) && (state_nxt_s == ST_RESP) && owner_r;
            if ((state_r == ST_ACCESS) && (state_nxt_s == ST_RESP)) begin
                if (owner_r) begin
                    r1_rdata_r <= cap_rdata_s;
                    r1_err_r   <= cap_err_s;
                end else begin
                    r0_rdata_r <= cap_rdata_s;
                    r0_err_r   <= cap_err_s;
                end
            end
        end
    end

    assign apb.psel    = psel_r;
    assign apb.penable = penable_r;
    assign apb.pwrite  = pwrite_r;
    assign apb.paddr   = paddr_r;
    assign apb.pwdata  = pwdata_r;
    assign apb.pstrb   = pstrb_r;
    assign busy        = busy_r;
    assign owner       = owner_r;
    assign r0_done     = r0_done_r;
    assign r1_done     = r1_done_r;
    assign r0_rdata    = r0_rdata_r;
    assign r1_rdata    = r1_rdata_r;
    assign r0_err      = r0_err_r;
    assign r1_err      = r1_err_r;

endmodule

// File: tb/tb_apb_arb2.sv
// Directed bench for apb_arb2: vector table of single transactions plus timeout and reset sequences.
module tb_apb_arb2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r1_req = 1'b0, r0_write = 1'b0, r1_write = 1'b0;
    logic [11:0] r0_addr = 12'h000, r1_addr = 12'h000;
    logic [31:0] r0_wdata = 32'h0, r1_wdata = 32'h0;
    logic [3:0]  r0_strb = 4'h0, r1_strb = 4'h0;
    logic        r0_done, r1_done, r0_err, r1_err, busy, owner;
    logic [31:0] r0_rdata, r1_rdata;

    logic [31:0] slave_rdata = 32'h0;
    logic        slave_err = 1'b0;
    logic        slave_dead = 1'b0;
    logic [3:0]  acc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    apb_arb2_if #(.AW(12)) bus ();

    apb_arb2 #(.TIMEOUT(4), .AW(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_strb(r0_strb), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_strb(r1_strb), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .busy(busy), .owner(owner), .apb(bus.master)
    );

    always #5 clk = ~clk;

    // One-wait-state slave: pready in the second ACCESS cycle unless it is dead.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 4'd0;
        else if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 4'd1;
        else acc_cnt <= 4'd0;
    end
    assign bus.pready  = bus.psel && bus.penable && !slave_dead && (acc_cnt >= 4'd1);
    assign bus.prdata  = slave_rdata;
    assign bus.pslverr = slave_err;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        q0, q1, w0, w1;
        logic [11:0] a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  s0, s1;
        logic [31:0] s_rdata;
        logic        s_err;
        logic        e_owner, e_pwrite;
        logic [11:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [3:0]  e_pstrb;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mkv(input logic q0, q1, w0, w1, input logic [11:0] a0, a1,
                                 input logic [31:0] d0, d1, input logic [3:0] s0, s1,
                                 input logic [31:0] srd, input logic serr,
                                 input logic eo, ew, input logic [11:0] ea,
                                 input logic [31:0] ed, input logic [3:0] es,
                                 input logic [31:0] er, input logic ee);
        vec_t v;
        v.q0 = q0; v.q1 = q1; v.w0 = w0; v.w1 = w1; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.s0 = s0; v.s1 = s1; v.s_rdata = srd; v.s_err = serr;
        v.e_owner = eo; v.e_pwrite = ew; v.e_paddr = ea; v.e_pwdata = ed;
        v.e_pstrb = es; v.e_rdata = er; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        r0_req = v.q0; r1_req = v.q1; r0_write = v.w0; r1_write = v.w1;
        r0_addr = v.a0; r1_addr = v.a1; r0_wdata = v.d0; r1_wdata = v.d1;
        r0_strb = v.s0; r1_strb = v.s1; slave_rdata = v.s_rdata; slave_err = v.s_err;
    endtask

    // Called at a negedge inside an IDLE cycle; returns at the negedge of the next IDLE cycle.
    task automatic run_vec(input vec_t v, input string tag);
        apply(v);
        @(negedge clk);
        chk({tag, " setup ctl"}, {60'd0, bus.psel, bus.penable, busy, owner}, {60'd0, 1'b1, 1'b0, 1'b1, v.e_owner});
        chk({tag, " setup bus"}, {15'd0, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb},
            {15'd0, v.e_pwrite, v.e_paddr, v.e_pwdata, v.e_pstrb});
        chk({tag, " setup done"}, {62'd0, r0_done, r1_done}, 64'd0);
        @(negedge clk);
        chk({tag, " access1"}, {61'd0, bus.psel, bus.penable, bus.pready}, {61'd0, 3'b110});
        @(negedge clk);
        chk({tag, " access2"}, {59'd0, bus.psel, bus.penable, bus.pready, r0_done, r1_done}, {59'd0, 5'b11100});
        @(negedge clk);
        chk({tag, " resp ctl"}, {61'd0, bus.psel, bus.penable, busy}, {61'd0, 3'b001});
        chk({tag, " resp done"}, {62'd0, r0_done, r1_done}, {62'd0, ~v.e_owner, v.e_owner});
        chk({tag, " resp data"}, {31'd0, (v.e_owner ? r1_err : r0_err), (v.e_owner ? r1_rdata : r0_rdata)},
            {31'd0, v.e_err, v.e_rdata});
        @(negedge clk);
        chk({tag, " idle"}, {61'd0, busy, r0_done, r1_done}, 64'd0);
    endtask

    vec_t tv;

    initial begin
        vecs[0] = mkv(1, 1, 1, 0, 12'h010, 12'h004, 32'h1111_0000, 32'h2222_0000, 4'hF, 4'h5, 32'hA5A5_0001, 0,
                      0, 1, 12'h010, 32'h1111_0000, 4'hF, 32'h0000_0000, 0);
        vecs[1] = mkv(1, 1, 1, 0, 12'h010, 12'h004, 32'h1111_0000, 32'h2222_0000, 4'hF, 4'h5, 32'hA5A5_0002, 0,
                      1, 0, 12'h004, 32'h2222_0000, 4'h0, 32'hA5A5_0002, 0);
        vecs[2] = mkv(1, 1, 1, 0, 12'h010, 12'h004, 32'h1111_0000, 32'h2222_0000, 4'hF, 4'h5, 32'hA5A5_0003, 0,
                      0, 1, 12'h010, 32'h1111_0000, 4'hF, 32'h0000_0000, 0);
        vecs[3] = mkv(1, 1, 1, 0, 12'h010, 12'h004, 32'h1111_0000, 32'h2222_0000, 4'hF, 4'h5, 32'hA5A5_0004, 0,
                      1, 0, 12'h004, 32'h2222_0000, 4'h0, 32'hA5A5_0004, 0);
        vecs[4] = mkv(1, 0, 1, 0, 12'h000, 12'h000, 32'h0000_0302, 32'h0, 4'hF, 4'h0, 32'h5555_5555, 0,
                      0, 1, 12'h000, 32'h0000_0302, 4'hF, 32'h0000_0000, 0);
        vecs[5] = mkv(0, 1, 0, 0, 12'h000, 12'h004, 32'h0, 32'h0, 4'h0, 4'h0, 32'hDEAD_BEEF, 0,
                      1, 0, 12'h004, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 0);
        vecs[6] = mkv(1, 0, 1, 0, 12'h000, 12'h000, 32'h0000_0900, 32'h0, 4'h2, 4'h0, 32'h0, 1,
                      0, 1, 12'h000, 32'h0000_0900, 4'h2, 32'h0000_0000, 1);
        vecs[7] = mkv(1, 0, 0, 0, 12'h008, 12'h000, 32'h0BAD_0BAD, 32'h0, 4'hF, 4'h0, 32'h1234_5678, 1,
                      0, 0, 12'h008, 32'h0BAD_0BAD, 4'h0, 32'h1234_5678, 1);

        repeat (2) @(negedge clk);
        chk("reset outputs", {4'd0, bus.psel, bus.penable, bus.pwrite, busy, owner, r0_done, r1_done, r0_err, r1_err,
                              bus.paddr, bus.pstrb, r0_rdata | r1_rdata | bus.pwdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Dead slave: ACCESS lasts exactly TIMEOUT cycles, then an error with zero data.
        slave_dead = 1'b1;
        tv = mkv(0, 1, 0, 0, 12'h000, 12'h00C, 32'h0, 32'h0, 4'h0, 4'h0, 32'hFFFF_FFFF, 0,
                 1, 0, 12'h00C, 32'h0, 4'h0, 32'h0, 1);
        apply(tv);
        @(negedge clk);
        chk("tmo setup", {62'd0, bus.psel, bus.penable}, {62'd0, 2'b10});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("tmo access%0d", k), {61'd0, bus.psel, bus.penable, r1_done}, {61'd0, 3'b110});
        end
        @(negedge clk);
        chk("tmo resp", {29'd0, bus.psel, bus.penable, r1_done, r1_err, r0_done, r1_rdata},
            {29'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0});
        r1_req = 1'b0;
        slave_dead = 1'b0;
        @(negedge clk);
        chk("tmo idle", {63'd0, busy}, 64'd0);
        tv = mkv(1, 0, 1, 0, 12'h014, 12'h000, 32'h0000_00AB, 32'h0, 4'h1, 4'h0, 32'h0, 0,
                 0, 1, 12'h014, 32'h0000_00AB, 4'h1, 32'h0, 0);
        run_vec(tv, "post tmo");

        // Reset during ACCESS of an r1 grant; afterwards a tie must go to r0.
        tv = mkv(1, 1, 1, 0, 12'h020, 12'h00C, 32'h0000_0077, 32'h0, 4'hF, 4'h0, 32'h0, 0,
                 0, 1, 12'h020, 32'h0000_0077, 4'hF, 32'h0, 0);
        apply(tv);
        @(negedge clk);
        chk("rst pre owner", {63'd0, owner}, 64'd1);
        @(negedge clk);
        chk("rst pre access", {62'd0, bus.psel, bus.penable}, {62'd0, 2'b11});
        #2 rst_n = 1'b0;
        #1 chk("rst async", {59'd0, bus.psel, bus.penable, busy, r0_done, r1_done}, 64'd0);
        @(negedge clk);
        chk("rst no done", {62'd0, r0_done, r1_done}, 64'd0);
        rst_n = 1'b1;
        run_vec(tv, "post rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
